// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end of the 5-stage pipeline.
// Owns the PC, issues icache reads and feeds the IF/ID latch.
//
// Ports:
//   CLK, RST          clock (rising edge), async active-high reset
//   imemREN/imemaddr  icache read request / address (address = PC)
//   ihit/imemload     icache response valid / instruction word
//   stall             hazard hold: IF/ID must not advance
//   redirect/_pc      taken branch/jump and its target
//   halt              stop fetching
//   fl_instr          IF/ID latch instruction input
//   fl_pc_plus_4      IF/ID latch PC+4 input
//   fl_en/fl_flush    IF/ID latch enable / flush (never both high)
//   fetch_count       instructions delivered to the latch since reset
//   halted            fetch permanently stopped until reset
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] fl_instr,
    output logic [31:0] fl_pc_plus_4,
    output logic        fl_en,
    output logic        fl_flush,
    output logic [31:0] fetch_count,
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        pend_valid, pend_valid_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic [31:0] cnt_n;
    logic        done;

    assign imemREN      = (state != HALTED);
    assign imemaddr     = pc;
    assign fl_instr     = imemload;
    assign fl_pc_plus_4 = pc + 32'd4;
    assign halted       = (state == HALTED);
    assign done         = imemREN & ihit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= RUN;
            pc          <= PC_INIT;
            pend_valid  <= 1'b0;
            pend_pc     <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_valid  <= pend_valid_n;
            pend_pc     <= pend_pc_n;
            fetch_count <= cnt_n;
        end
    end

    // PC only moves on a completed access, so the icache address stays
    // stable for the whole of a miss. Redirects that land mid-miss are
    // parked in pend_pc and applied when the outstanding access returns.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_valid_n = pend_valid;
        pend_pc_n    = pend_pc;
        cnt_n        = fetch_count;
        fl_en        = 1'b0;
        fl_flush     = 1'b0;
        case (state)
            RUN: begin
                if (halt) begin
                    state_n      = (done || !imemREN) ? HALTED : DRAIN;
                    fl_flush     = 1'b1;
                    pend_valid_n = 1'b0;
                    pend_pc_n    = 32'd0;
                end else if (redirect && done) begin
                    pc_n         = redirect_pc;
                    fl_flush     = 1'b1;
                    pend_valid_n = 1'b0;
                end else if (redirect) begin
                    // latest redirect wins if several arrive in one miss
                    pend_valid_n = 1'b1;
                    pend_pc_n    = redirect_pc;
                    fl_flush     = 1'b1;
                end else if (done && pend_valid) begin
                    // word belongs to the wrong path: drop it, no flush needed
                    pc_n         = pend_pc;
                    pend_valid_n = 1'b0;
                end else if (done && stall) begin
                    // re-read the same address next cycle
                    pc_n = pc;
                end else if (done) begin
                    pc_n  = pc + 32'd4;
                    fl_en = 1'b1;
                    cnt_n = fetch_count + 32'd1;
                end
            end
            DRAIN: begin
                // let the outstanding access finish before going quiet
                if (ihit) state_n = HALTED;
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

endmodule
